// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/redirect controller: stage indices,
// controller FSM states and control-level encodings.
package pipe_ctrl_pkg;

    localparam int StagePc    = 0;
    localparam int StageIfId  = 1;
    localparam int StageIdEx  = 2;
    localparam int StageExMem = 3;
    localparam int StageMemWb = 4;

    localparam logic Enable       = 1'b1;
    localparam logic Disable      = 1'b0;
    localparam logic StallEnable  = 1'b1;
    localparam logic StallDisable = 1'b0;

    typedef enum logic [1:0] {
        CtrlRun    = 2'd0,
        CtrlFreeze = 2'd1,
        CtrlFlush  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: per-stage hold/bubble generation,
// multi-cycle flush sequencing and saturating stall/flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE       = 5,
    parameter int AW           = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CW           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic              flush_req_i,
    input  logic [AW-1:0]     flush_pc_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] bubble_o,
    output logic              flush_o,
    output logic [AW-1:0]     new_pc_o,
    output logic              busy_o,
    output logic [CW-1:0]     stall_cnt_o,
    output logic [CW-1:0]     flush_cnt_o
);

    localparam int KW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam int DW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DW-1:0] DownLoad = DW'(FLUSH_CYCLES - 1);

    ctrl_state_e       state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [DW-1:0]     down_q, down_d;

    logic [KW-1:0]     k;
    logic              k_vld;
    logic [NSTAGE-1:0] run_stall;
    logic [NSTAGE-1:0] run_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CtrlRun;
            pc_q    <= '0;
            down_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            down_q  <= down_d;
        end
    end

    // A redirect in any state recaptures the target and restarts the sequence.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        down_d  = down_q;
        if (flush_req_i) begin
            pc_d = flush_pc_i;
            if (FLUSH_CYCLES > 1) begin
                state_d = CtrlFreeze;
            end else begin
                state_d = CtrlFlush;
                down_d  = DownLoad;
            end
        end else begin
            case (state_q)
                CtrlFreeze: begin
                    state_d = CtrlFlush;
                    down_d  = DownLoad;
                end
                CtrlFlush: begin
                    if (down_q == '0) begin
                        state_d = CtrlRun;
                    end else begin
                        down_d = down_q - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        k          = '0;
        k_vld      = 1'b0;
        run_stall  = '0;
        run_bubble = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (stallreq_i[i]) begin
                k     = KW'(i);
                k_vld = 1'b1;
            end
        end
        for (int j = 0; j < NSTAGE; j++) begin
            run_stall[j]  = k_vld && (j <= int'(k));
            run_bubble[j] = k_vld && (j == int'(k) + 1);
        end
    end

    // Controls are forced idle while rst is high so the reset cycle itself is quiet.
    always_comb begin
        stall_o  = '0;
        bubble_o = '0;
        flush_o  = 1'b0;
        busy_o   = 1'b0;
        if (!rst) begin
            case (state_q)
                CtrlRun: begin
                    if (flush_req_i) begin
                        stall_o = {NSTAGE{StallEnable}};
                    end else begin
                        stall_o  = run_stall;
                        bubble_o = run_bubble;
                    end
                end
                CtrlFreeze: begin
                    stall_o = {NSTAGE{StallEnable}};
                    busy_o  = 1'b1;
                end
                CtrlFlush: begin
                    bubble_o = {NSTAGE{1'b1}};
                    flush_o  = 1'b1;
                    busy_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign new_pc_o = pc_q;

    sat_counter #(.W(CW)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (|stall_o),
        .cnt (stall_cnt_o)
    );

    sat_counter #(.W(CW)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_req_i),
        .cnt (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (FLUSH_CYCLES=1/CW=4 and
// FLUSH_CYCLES=3/CW=16) share stimulus and are checked against a phase-count model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int N    = 5;
    localparam int AW   = 32;
    localparam int FC_A = 1;
    localparam int FC_B = 3;
    localparam int CW_A = 4;
    localparam int CW_B = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  sr  = '0;
    logic          fr  = 1'b0;
    logic [AW-1:0] fpc = '0;

    logic [N-1:0]    a_stall, a_bubble, b_stall, b_bubble;
    logic            a_flush, a_busy, b_flush, b_busy;
    logic [AW-1:0]   a_pc, b_pc;
    logic [CW_A-1:0] a_scnt, a_fcnt;
    logic [CW_B-1:0] b_scnt, b_fcnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGE(N), .AW(AW), .FLUSH_CYCLES(FC_A), .CW(CW_A)) dut_a (
        .clk(clk), .rst(rst), .stallreq_i(sr), .flush_req_i(fr), .flush_pc_i(fpc),
        .stall_o(a_stall), .bubble_o(a_bubble), .flush_o(a_flush), .new_pc_o(a_pc),
        .busy_o(a_busy), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
    );

    pipe_ctrl #(.NSTAGE(N), .AW(AW), .FLUSH_CYCLES(FC_B), .CW(CW_B)) dut_b (
        .clk(clk), .rst(rst), .stallreq_i(sr), .flush_req_i(fr), .flush_pc_i(fpc),
        .stall_o(b_stall), .bubble_o(b_bubble), .flush_o(b_flush), .new_pc_o(b_pc),
        .busy_o(b_busy), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    typedef struct packed {
        logic [N-1:0]  stall;
        logic [N-1:0]  bubble;
        logic          flush;
        logic [AW-1:0] pc;
        logic          busy;
        logic [15:0]   scnt;
        logic [15:0]   fcnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: remaining frozen / flushing cycles, counters and target.
    int            fc[2]          = '{FC_A, FC_B};
    int            cmax[2]        = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    int            freeze_left[2] = '{0, 0};
    int            flush_left[2]  = '{0, 0};
    int            scnt[2]        = '{0, 0};
    int            fcnt[2]        = '{0, 0};
    logic [AW-1:0] tgt[2]         = '{32'h0, 32'h0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle(input int i, output exp_t e);
        int   k;
        logic frozen, flushing;
        frozen   = freeze_left[i] > 0;
        flushing = !frozen && (flush_left[i] > 0);
        e      = '0;
        e.pc   = tgt[i];
        e.scnt = 16'(scnt[i]);
        e.fcnt = 16'(fcnt[i]);
        if (!rst) begin
            e.busy = frozen || flushing;
            if (flushing) begin
                e.flush  = 1'b1;
                e.bubble = '1;
            end else if (frozen || fr) begin
                e.stall = '1;
            end else begin
                k = -1;
                for (int b = N - 1; b >= 0; b--) begin
                    if (sr[b]) begin
                        k = b;
                        break;
                    end
                end
                if (k >= 0) begin
                    e.stall = N'((1 << (k + 1)) - 1);
                    if (k + 1 < N) e.bubble = N'(1 << (k + 1));
                end
            end
        end
        if (rst) begin
            freeze_left[i] = 0;
            flush_left[i]  = 0;
            scnt[i]        = 0;
            fcnt[i]        = 0;
            tgt[i]         = '0;
        end else begin
            if (e.stall != '0 && scnt[i] < cmax[i]) scnt[i]++;
            if (fr) begin
                if (fcnt[i] < cmax[i]) fcnt[i]++;
                tgt[i]         = fpc;
                freeze_left[i] = (fc[i] > 1) ? 1 : 0;
                flush_left[i]  = fc[i];
            end else if (frozen) begin
                freeze_left[i] = 0;
            end else if (flushing) begin
                flush_left[i]--;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] s, input logic f, input logic [AW-1:0] p);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        sr  = s;
        fr  = f;
        fpc = p;
        model_cycle(0, e);
        q_a.push_back(e);
        model_cycle(1, e);
        q_b.push_back(e);
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [N-1:0] st,
                           input logic [N-1:0] bu, input logic fl, input logic [AW-1:0] pc,
                           input logic bz, input logic [15:0] sc, input logic [15:0] fc_v);
        check({tag, ".stall_o"},     st,   e.stall);
        check({tag, ".bubble_o"},    bu,   e.bubble);
        check({tag, ".flush_o"},     fl,   e.flush);
        check({tag, ".new_pc_o"},    pc,   e.pc);
        check({tag, ".busy_o"},      bz,   e.busy);
        check({tag, ".stall_cnt_o"}, sc,   e.scnt);
        check({tag, ".flush_cnt_o"}, fc_v, e.fcnt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                compare("a", e, a_stall, a_bubble, a_flush, a_pc, a_busy, 16'(a_scnt), 16'(a_fcnt));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                compare("b", e, b_stall, b_bubble, b_flush, b_pc, b_busy, 16'(b_scnt), 16'(b_fcnt));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset with every request asserted must still produce quiet outputs.
        drive(1'b1, '1, 1'b1, 32'hdead_beef);
        drive(1'b1, '1, 1'b1, 32'hdead_beef);
        #5;
        check("rst.a.stall_o", a_stall, 0);
        check("rst.a.bubble_o", a_bubble, 0);
        check("rst.b.busy_o", b_busy, 0);
        check("rst.b.flush_cnt_o", b_fcnt, 0);

        drive(1'b0, 5'b00100, 1'b0, '0);
        #5;
        check("idex.stall_o", a_stall, 5'b00111);
        check("idex.bubble_o", a_bubble, 5'b01000);
        drive(1'b0, 5'b00100, 1'b0, '0);
        drive(1'b0, 5'b00100, 1'b0, '0);

        drive(1'b0, 5'b10010, 1'b0, '0);
        #5;
        check("memwb.stall_o", a_stall, 5'b11111);
        check("memwb.bubble_o", a_bubble, 5'b00000);
        check("idex.stall_cnt_o", a_scnt, 3);
        drive(1'b0, 5'b00011, 1'b0, '0);
        #5;
        check("ifid.stall_o", a_stall, 5'b00011);
        check("ifid.bubble_o", a_bubble, 5'b00100);

        drive(1'b0, 5'b00001, 1'b1, 32'h0000_0140);
        #5;
        check("fl1.req.stall_o", a_stall, 5'b11111);
        drive(1'b0, '0, 1'b0, '0);
        #5;
        check("fl1.flush_o", a_flush, 1);
        check("fl1.bubble_o", a_bubble, 5'b11111);
        check("fl1.new_pc_o", a_pc, 32'h140);
        drive(1'b0, '0, 1'b0, '0);
        #5;
        check("fl1.busy_o", a_busy, 0);
        check("fl1.flush_cnt_o", a_fcnt, 1);
        repeat (4) drive(1'b0, '0, 1'b0, '0);

        // Three-cycle flush restarted from its second FLUSH cycle.
        drive(1'b1, '0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 32'h0000_0100);
        drive(1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 32'h0000_0200);
        #5;
        check("fl3.second.flush_o", b_flush, 1);
        drive(1'b0, '0, 1'b0, '0);
        #5;
        check("fl3.freeze.stall_o", b_stall, 5'b11111);
        check("fl3.new_pc_o", b_pc, 32'h200);
        drive(1'b0, '0, 1'b0, '0);
        #5;
        check("fl3.restart.flush_o", b_flush, 1);
        check("fl3.flush_cnt_o", b_fcnt, 2);
        repeat (4) drive(1'b0, '0, 1'b0, '0);

        repeat (20) drive(1'b0, 5'b00001, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0);
        #5;
        check("sat.stall_cnt_o", a_scnt, 15);

        // Reset lands in b's first FLUSH cycle.
        drive(1'b0, '0, 1'b1, 32'h0000_003c);
        drive(1'b0, '0, 1'b0, '0);
        drive(1'b1, '0, 1'b0, '0);
        #5;
        check("rstfl.during.flush_o", b_flush, 0);
        drive(1'b0, '0, 1'b0, '0);
        #5;
        check("rstfl.flush_o", b_flush, 0);
        check("rstfl.new_pc_o", b_pc, 0);
        check("rstfl.busy_o", b_busy, 0);

        repeat (400) begin
            drive($urandom_range(0, 63) == 0, N'($urandom), $urandom_range(0, 7) == 0, $urandom);
        end
        drive(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("scoreboard.a.drained", q_a.size(), 0);
        check("scoreboard.b.drained", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
